// File: rtl/des_pkg.sv
// DES geometry, permutation tables, S-boxes and bit-level helpers.
// Bit 0 of every vector is DES bit 1 (MSB), so a table entry n selects index n-1.
package des_pkg;

   localparam int BLOCK_W    = 64;
   localparam int HALF_W     = 32;
   localparam int KEY_HALF_W = 28;
   localparam int RKEY_W     = 48;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} des_dec_state_t;

   localparam logic [6:0] IP_TBL [0:63] = '{
      58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

   localparam logic [6:0] FP_TBL [0:63] = '{
      40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

   localparam logic [6:0] PC1_TBL [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam logic [6:0] PC2_TBL [0:47] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam logic [5:0] E_TBL [0:47] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam logic [5:0] P_TBL [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   // Right-rotate amount applied after round rnd is entry rnd+1; entry 0 covers the final round.
   localparam logic [1:0] DEC_ROT [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Indexed by {row, col} = {b1, b6, b2..b5}.
   localparam logic [3:0] SBOX_TBL [0:7][0:63] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

   function automatic logic [0:63] ip_perm(input logic [0:63] x);
      logic [0:63] y;
      for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_TBL[6'(i)] - 7'd1)];
      return y;
   endfunction

   function automatic logic [0:63] fp_perm(input logic [0:63] x);
      logic [0:63] y;
      for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_TBL[6'(i)] - 7'd1)];
      return y;
   endfunction

   function automatic logic [0:55] pc1_perm(input logic [0:63] x);
      logic [0:55] y;
      for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_TBL[6'(i)] - 7'd1)];
      return y;
   endfunction

   function automatic logic [0:47] pc2_perm(input logic [0:55] x);
      logic [0:47] y;
      for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_TBL[6'(i)] - 7'd1)];
      return y;
   endfunction

   function automatic logic [0:47] e_expand(input logic [0:31] x);
      logic [0:47] y;
      for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_TBL[6'(i)] - 6'd1)];
      return y;
   endfunction

   function automatic logic [0:31] p_perm(input logic [0:31] x);
      logic [0:31] y;
      for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_TBL[5'(i)] - 6'd1)];
      return y;
   endfunction

   function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] amt);
      case (amt)
         2'd1:    return {x[27], x[0:26]};
         2'd2:    return {x[26:27], x[0:25]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_feistel.sv
// DES round function f(R, K): expansion, key mix, eight S-boxes, P permutation.
// Purely combinational; shared by the encrypt pipeline and the decrypt core.
module des_feistel
   import des_pkg::*;
(
   input  logic [0:31] f_input_wires,
   input  logic [0:47] round_key,
   output logic [0:31] f_output_wires
);

   logic [0:47] w_mixed;
   logic [0:31] w_sbox_out;

   assign w_mixed = e_expand(f_input_wires) ^ round_key;

   for (genvar g = 0; g < 8; g++) begin : g_sbox
      logic [5:0] w_chunk;
      assign w_chunk = w_mixed[6*g +: 6];
      assign w_sbox_out[4*g +: 4] = SBOX_TBL[g][{w_chunk[5], w_chunk[0], w_chunk[4:1]}];
   end

   assign f_output_wires = p_perm(w_sbox_out);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock with an inline reverse
// key schedule (K16 first), framed by valid/ready handshakes on both sides.
module des_decrypt_core
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [0:63] ciphertext,
   input  logic [0:63] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [0:63] plaintext
);

   des_dec_state_t r_state, w_next_state;

   logic [0:31] r_l, r_r;
   logic [0:27] r_c, r_d;
   logic [3:0]  r_rnd;
   logic [0:63] r_plaintext;

   logic [0:63] w_ip;
   logic [0:55] w_pc1;
   logic [0:47] w_round_key;
   logic [0:31] w_f;
   logic [0:31] w_r_next;
   logic [3:0]  w_rnd_next;
   logic [1:0]  w_rot;

   assign w_ip        = ip_perm(ciphertext);
   assign w_pc1       = pc1_perm(key);
   assign w_round_key = pc2_perm({r_c, r_d});
   assign w_r_next    = r_l ^ w_f;
   assign w_rnd_next  = r_rnd + 4'd1;
   assign w_rot       = DEC_ROT[w_rnd_next];

   des_feistel u_feistel (
      .f_input_wires  (r_r),
      .round_key      (w_round_key),
      .f_output_wires (w_f)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid)          w_next_state = ROUND;
         ROUND:   if (r_rnd == 4'd15)    w_next_state = DONE;
         DONE:    if (out_ready)         w_next_state = IDLE;
         default:                        w_next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      plaintext = r_plaintext;
   end

   // NOTE: the datapath is cleared on reset too, so an aborted block never leaks onto plaintext.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_l         <= '0;
         r_r         <= '0;
         r_c         <= '0;
         r_d         <= '0;
         r_rnd       <= '0;
         r_plaintext <= '0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_l   <= w_ip[0:31];
               r_r   <= w_ip[32:63];
               r_c   <= w_pc1[0:27];
               r_d   <= w_pc1[28:55];
               r_rnd <= '0;
            end
            ROUND: begin
               r_l   <= r_r;
               r_r   <= w_r_next;
               r_c   <= rotr28(r_c, w_rot);
               r_d   <= rotr28(r_d, w_rot);
               r_rnd <= w_rnd_next;
               // Last round: swap halves straight from this round's results into FP.
               if (r_rnd == 4'd15) r_plaintext <= fp_perm({w_r_next, r_r});
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors, back-to-back,
// back-pressure, parity-bit insensitivity, input stability and mid-block reset.
module tb_des_decrypt_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [0:63] ciphertext = '0;
   logic [0:63] key = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [0:63] plaintext;

   int   total = 0;
   int   bad   = 0;
   logic overlap_seen = 1'b0;

   localparam logic [0:63] KEY1  = 64'h133457799BBCDFF1;
   localparam logic [0:63] KEY1P = 64'h123556789ABDDEF0;
   localparam logic [0:63] CT1   = 64'h85E813540F0AB405;
   localparam logic [0:63] PT1   = 64'h0123456789ABCDEF;
   localparam logic [0:63] KEY2  = 64'h0E329232EA6D0D73;
   localparam logic [0:63] CT2   = 64'h0000000000000000;
   localparam logic [0:63] PT2   = 64'h8787878787878787;

   des_decrypt_core dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (in_ready && out_valid) overlap_seen <= 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [0:63] ct, input logic [0:63] k);
      check("accept_in_ready", 64'(in_ready), 64'd1);
      ciphertext = ct;
      key        = k;
      in_valid   = 1'b1;
      step();
      in_valid   = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int hits;

      // Reset state
      step();
      step();
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_plaintext", plaintext,      64'd0);
      rst = 1'b0;
      step();

      // Vector 1, latency and single-cycle transfer
      accept(CT1, KEY1);
      wait_out(n);
      check("v1_latency",     64'(n),        64'd16);
      check("v1_plaintext",   plaintext,     PT1);
      check("v1_in_ready_lo", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      step();
      check("v1_out_valid_drop", 64'(out_valid), 64'd0);
      check("v1_in_ready_back",  64'(in_ready),  64'd1);

      // Vector 2 back-to-back with in_valid held, inputs disturbed during the second block
      ciphertext = CT2;
      key        = KEY2;
      in_valid   = 1'b1;
      step();
      hits = 0;
      for (int e = 1; e <= 18; e++) begin
         step();
         if (e <= 16 && in_ready) hits++;
         if (e == 16) begin
            check("v2_out_valid", 64'(out_valid), 64'd1);
            check("v2_plaintext", plaintext,      PT2);
         end
         if (e == 17) begin
            check("v2_in_ready_17",  64'(in_ready),  64'd1);
            check("v2_out_valid_17", 64'(out_valid), 64'd0);
         end
         if (e == 18) check("v2_reaccept_18", 64'(in_ready), 64'd0);
      end
      check("v2_in_ready_low_1_16", 64'(hits), 64'd0);
      in_valid   = 1'b0;
      ciphertext = 64'hFFFF_0000_A5A5_5A5A;
      key        = 64'hDEAD_BEEF_CAFE_F00D;
      step();
      ciphertext = 64'h0123_4567_89AB_CDEF;
      key        = 64'h0;
      wait_out(n);
      check("v2b_latency",   64'(n),    64'd15);
      check("v2b_plaintext", plaintext, PT2);
      step();

      // Back-pressure for 10 cycles
      out_ready = 1'b0;
      accept(CT1, KEY1);
      wait_out(n);
      check("bp_latency", 64'(n), 64'd16);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid !== 1'b1 || plaintext !== PT1 || in_ready !== 1'b0) hits++;
      end
      check("bp_hold_violations", 64'(hits), 64'd0);
      out_ready = 1'b1;
      step();
      check("bp_out_valid_drop", 64'(out_valid), 64'd0);
      check("bp_in_ready_back",  64'(in_ready),  64'd1);

      // Parity bits inverted
      accept(CT1, KEY1P);
      wait_out(n);
      check("parity_latency",   64'(n),    64'd16);
      check("parity_plaintext", plaintext, PT1);
      step();

      // Reset during round 7, then a fresh block
      accept(CT2, KEY2);
      repeat (7) step();
      check("mid_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b1;
      #1;
      check("abort_in_ready",  64'(in_ready),  64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_plaintext", plaintext,      64'd0);
      #2;
      rst = 1'b0;
      step();
      check("abort_idle", 64'(in_ready), 64'd1);
      accept(CT1, KEY1);
      wait_out(n);
      check("post_rst_latency",   64'(n),    64'd16);
      check("post_rst_plaintext", plaintext, PT1);
      step();

      check("no_ready_valid_overlap", 64'(overlap_seen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
